// File: rtl/instr_encoder.sv
// Instruction encoder: turns mnemonic beats into 32-bit MIPS-style words and streams them into instruction memory.
// Optional ENC_HALT_PAD_EN appends a jump-to-self halt word after the last instruction of a session.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [7:0]  count,
  output logic        done,
  output logic        err
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | accepting beats, one write per accept
  // PAD    | halt word being written (ENC_HALT_PAD_EN only)
  // DONE   | one-cycle completion pulse
`ifdef ENC_HALT_PAD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PAD = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd3} state_t;
`endif

  localparam logic [7:0] MAXW = 8'(MAX_WORDS);

  state_t      state;
  logic        fin;
  logic [31:0] waddr;
  logic [31:0] enc_word;
  logic        enc_bad;
  logic        accept;

  always_comb begin
    enc_word = 32'h0000_0000;
    enc_bad  = 1'b0;
    case (in_op)
      4'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      4'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      4'd2: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
      4'd3: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
      4'd4: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
      4'd5: enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
      4'd6: enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
      4'd7: enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
      4'd8: enc_word = {6'b001000, in_rs, in_rt, in_imm[15:0]};
      4'd9: enc_word = {6'b000010, in_imm};
      default: enc_bad = 1'b1;
    endcase
  end

  // fin blocks new beats while the closing write is still in flight
  assign in_ready = (state == S_LOAD) && !fin && (count < MAXW);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fin        <= 1'b0;
      waddr      <= BASE_ADDR;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0000_0000;
      count      <= 8'd0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            waddr <= BASE_ADDR;
            count <= 8'd0;
            err   <= 1'b0;
            fin   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= waddr;
            imem_wdata <= enc_word;
            waddr      <= waddr + 32'd4;
            count      <= count + 8'd1;
            if (enc_bad) err <= 1'b1;
            if (in_last || (count + 8'd1 == MAXW)) begin
              fin <= 1'b1;
              if (!in_last) err <= 1'b1;
            end
          end else if (fin) begin
            fin <= 1'b0;
`ifdef ENC_HALT_PAD_EN
            if (count < MAXW) begin
              imem_we    <= 1'b1;
              imem_addr  <= waddr;
              imem_wdata <= {6'b000010, waddr[27:2]};
              waddr      <= waddr + 32'd4;
              count      <= count + 8'd1;
              state      <= S_PAD;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
`else
            state <= S_DONE;
            done  <= 1'b1;
`endif
          end
        end
`ifdef ENC_HALT_PAD_EN
        S_PAD: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: cycle model of expected writes/handshake plus directed literal checks.
// Honours ENC_HALT_PAD_EN when the same macro is defined for the build.
module tb_instr_encoder;
  localparam int MAIN_MAX = 64;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_s = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [25:0] in_imm = '0;

  logic        in_ready, imem_we, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [7:0]  count;
  logic        s_ready, s_we, s_done, s_err;
  logic [31:0] s_addr, s_wdata;
  logic [7:0]  s_count;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0), .MAX_WORDS(MAIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err(err));

  instr_encoder #(.BASE_ADDR(32'h0), .MAX_WORDS(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid), .in_ready(s_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .count(s_count), .done(s_done), .err(s_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_enc(input int op, input int rs, input int rt,
                                            input int rd, input logic [25:0] imm);
    int opc [10];
    int fn [10];
    logic [31:0] w;
    opc = '{0, 0, 0, 0, 0, 35, 43, 4, 8, 2};
    fn  = '{32, 34, 36, 37, 42, 0, 0, 0, 0, 0};
    if (op > 9) return 32'h0;
    w = 32'(opc[op]) << 26;
    if (op == 9) return w | 32'(imm);
    w = w | (32'(rs) << 21) | (32'(rt) << 16);
    if (op < 5) return w | (32'(rd) << 11) | 32'(fn[op]);
    return w | 32'(imm[15:0]);
  endfunction

  // Model: schedule of expected writes and done pulse by cycle number
  int          cyc = 0, done_cyc = -1, acc = 0, sess = 0;
  bit          active = 0, accepting = 0, m_err = 0;
  logic [31:0] nxt = 32'h0;
  logic [31:0] exp_data [int];
  logic [31:0] exp_addr [int];

  initial begin
    int p, now;
    forever begin
      @(posedge clk);
      p = cyc;
      cyc++;
      now = cyc;
      if (!rst_n) begin
        active = 0; accepting = 0; m_err = 0; acc = 0; done_cyc = -1; sess++;
        exp_data.delete(); exp_addr.delete();
      end else if (!active) begin
        if (start) begin
          active = 1; accepting = 1; nxt = 32'h0; acc = 0; m_err = 0; sess++;
        end
      end else begin
        if (accepting && acc < MAIN_MAX && in_valid) begin
          exp_data[now] = model_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), in_imm);
          exp_addr[now] = nxt;
          nxt += 4;
          acc++;
          if (in_op > 4'd9) m_err = 1;
          if (in_last || acc == MAIN_MAX) begin
            accepting = 0;
            if (!in_last) m_err = 1;
            done_cyc = now + 1;
`ifdef ENC_HALT_PAD_EN
            if (acc < MAIN_MAX) begin
              exp_data[now + 1] = 32'h0800_0000 | (nxt >> 2);
              exp_addr[now + 1] = nxt;
              nxt += 4;
              acc++;
              done_cyc = now + 2;
            end
`endif
          end
        end
        if (p == done_cyc) active = 0;
      end
    end
  end

  initial begin
    int now, seen_sess, written;
    bit exp_we;
    seen_sess = -1;
    written = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        now = cyc;
        if (sess != seen_sess) begin seen_sess = sess; written = 0; end
        exp_we = exp_data.exists(now);
        if (exp_we) written++;
        chk("model_we", 32'(imem_we), 32'(exp_we));
        if (exp_we && imem_we) begin
          chk("model_addr", imem_addr, exp_addr[now]);
          chk("model_data", imem_wdata, exp_data[now]);
        end
        chk("model_ready", 32'(in_ready), 32'(active && accepting && acc < MAIN_MAX));
        chk("model_count", 32'(count), 32'(written));
        chk("model_err", 32'(err), 32'(m_err));
        chk("model_done", 32'(done), 32'(now == done_cyc));
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input logic last);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 12 && !done; i++) begin
      @(posedge clk); #1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD with last
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1);
    idle_in();
    chk("add_we", 32'(imem_we), 32'd1);
    chk("add_addr", imem_addr, 32'h0);
    chk("add_data", imem_wdata, 32'h0022_1820);
    wait_done("add_done");
`ifdef ENC_HALT_PAD_EN
    chk("add_count", 32'(count), 32'd2);
`else
    chk("add_count", 32'(count), 32'd1);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", 32'(in_ready), 32'd0);
    @(posedge clk); #1;

    // Back-to-back LW then BEQ
    do_start();
    send(4'd5, 5'd29, 5'd8, 5'd0, 26'd4, 1'b0);
    chk("lw_data", imem_wdata, 32'h8FA8_0004);
    chk("lw_addr", imem_addr, 32'h0);
    send(4'd7, 5'd1, 5'd2, 5'd0, 26'h0FFFF, 1'b1);
    idle_in();
    chk("beq_we", 32'(imem_we), 32'd1);
    chk("beq_data", imem_wdata, 32'h1022_FFFF);
    chk("beq_addr", imem_addr, 32'h4);
    wait_done("beq_done");
    @(posedge clk); #1;

    // Three beats ending in last (pad case when enabled)
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    send(4'd1, 5'd5, 5'd6, 5'd4, 26'd0, 1'b0);
    chk("sub_data", imem_wdata, 32'h00A6_2022);
    send(4'd9, 5'd0, 5'd0, 5'd0, 26'h10, 1'b1);
    idle_in();
    chk("j_data", imem_wdata, 32'h0800_0010);
    @(posedge clk); #1;
`ifdef ENC_HALT_PAD_EN
    chk("pad_we", 32'(imem_we), 32'd1);
    chk("pad_addr", imem_addr, 32'hC);
    chk("pad_data", imem_wdata, 32'h0800_0003);
    chk("pad_count", 32'(count), 32'd4);
    @(posedge clk); #1;
`else
    chk("nopad_we", 32'(imem_we), 32'd0);
    chk("nopad_count", 32'(count), 32'd3);
`endif
    chk("three_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Illegal op, with a stall and an ignored mid-session start
    do_start();
    send(4'd3, 5'd7, 5'd8, 5'd9, 26'd0, 1'b0);
    idle_in();
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    chk("midstart_count", 32'(count), 32'd1);
    send(4'd12, 5'd1, 5'd2, 5'd3, 26'h3FF, 1'b1);
    idle_in();
    chk("illegal_data", imem_wdata, 32'h0);
    chk("illegal_err", 32'(err), 32'd1);
    wait_done("illegal_done");
    chk("illegal_err_at_done", 32'(err), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("illegal_err_hold", 32'(err), 32'd1);
    do_start();
    chk("err_cleared_by_start", 32'(err), 32'd0);
    send(4'd8, 5'd3, 5'd4, 5'd0, 26'h8001, 1'b1);
    idle_in();
    chk("addi_data", imem_wdata, 32'h2064_8001);
    wait_done("addi_done");
    @(posedge clk); #1;

    // Overflow on the MAX_WORDS=2 instance
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    chk("ovf_w1", {s_addr[30:0], s_we}, 32'h1);
    send(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    chk("ovf_w2_we", 32'(s_we), 32'd1);
    chk("ovf_w2_addr", s_addr, 32'h4);
    chk("ovf_ready_low", 32'(s_ready), 32'd0);
    send(4'd4, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    idle_in();
    chk("ovf_no_w3", 32'(s_we), 32'd0);
    chk("ovf_count", 32'(s_count), 32'd2);
    chk("ovf_err", 32'(s_err), 32'd1);
    chk("ovf_done", 32'(s_done), 32'd1);
    @(posedge clk); #1;

    // Reset mid-session, then restart at base
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    send(4'd12, 5'd5, 5'd6, 5'd4, 26'd0, 1'b0);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_we", 32'(imem_we), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_wdata", imem_wdata, 32'h0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    send(4'd4, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1);
    idle_in();
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_data", imem_wdata, 32'h0022_182A);
    wait_done("restart_done");
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction written.
REQ-002 SHALL have parameter MAX_WORDS, default 64, range 1..255: capacity of one load session in words.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begins a load session while IDLE.
REQ-006 SHALL have port in_valid  input  1  instruction beat valid.
REQ-007 SHALL have port in_ready  output  1  encoder accepts beat.
REQ-008 SHALL have port in_op  input  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10-15 illegal.
REQ-009 SHALL have ports in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-010 SHALL have port in_imm  input  26  imm[15:0] for I-type, imm[25:0] for J.
REQ-011 SHALL have port in_last  input  1  final beat of session.
REQ-012 SHALL have ports imem_we (output, 1), imem_addr (output, 32) and imem_wdata (output, 32): instruction-memory write port.
REQ-013 SHALL have ports count (output, 8), done (output, 1) and err (output, 1): words written, one-cycle completion pulse, and sticky error.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, PAD and DONE.
REQ-015 IDLE: start=1 SHALL move to LOAD, load the address to BASE_ADDR, and clear count and err.
REQ-016 in_ready SHALL be 1 only in LOAD when count<MAX_WORDS and no write is pending to the same cycle's slot.
REQ-017 SHALL sustain one accept per cycle.
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-019 Latency SHALL be 1: imem_we is 1 the cycle after accept, with the encoded word and the current address.
REQ-020 After each write, the address SHALL increment by 4 and count by 1.
REQ-021 R-type instructions SHALL encode as opcode 000000, rs, rt, rd, shamt 0 and funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
REQ-022 I-type instructions SHALL encode with opcode LW 100011, SW 101011, BEQ 000100 or ADDI 001000, then rs, rt and imm[15:0].
REQ-023 J SHALL encode as opcode 000010 followed by imm[25:0].
REQ-024 An illegal in_op SHALL write 32'h0000_0000 (NOP) and set err.
REQ-025 An accepted in_last SHALL, after its write, move to PAD when the macro is defined, otherwise to DONE.
REQ-026 When count reaches MAX_WORDS without in_last, the FSM SHALL set err and finish as for in_last; further beats see in_ready=0.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE; count and err SHALL hold until the next start.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 in_ready SHALL be 0 in IDLE, PAD and DONE.
REQ-030 imem_we SHALL be 0 except in write cycles.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, with in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0 and err=0, including mid-session; the partial session is abandoned.

Configuration
REQ-032 With ENC_HALT_PAD_EN defined, PAD SHALL write one extra word, a jump-to-self (opcode 000010, target = imem_addr[27:2]), at the next address, count it, and then go to DONE.
REQ-033 Without ENC_HALT_PAD_EN, the PAD state SHALL be absent and the last write SHALL go directly to DONE.
REQ-034 With ENC_HALT_PAD_EN defined, the pad word SHALL be written even when the session ended by overflow, provided count<MAX_WORDS; otherwise it SHALL be skipped.

Verification
REQ-035 start, then ADD rd=3 rs=1 rt=2 with in_last=1 -> one cycle later imem_we=1, addr 0x0, data 0x00221820, followed by a done pulse and count=1 (no pad).
REQ-036 Back-to-back beats LW rt=8 rs=29 imm=4 then BEQ rs=1 rt=2 imm=0xFFFF -> writes 0x8FA80004 at address 0x0 and 0x1022FFFF at address 0x4 on consecutive cycles.
REQ-037 With ENC_HALT_PAD_EN, three beats ending in in_last -> fourth write 0x08000003 at address 0xC, count=4, then done.
REQ-038 in_op=12 -> write 0x00000000 and err=1, which stays 1 through done until the next start.
REQ-039 MAX_WORDS=2 with three valid beats and no in_last -> two writes, in_ready=0 thereafter, err=1, and done asserted.
REQ-040 rst_n low for one cycle mid-session -> all outputs reach their reset values asynchronously; a subsequent start restarts at BASE_ADDR.
